// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Owns the single write port of the register file. Two result producers
// share it:
//   port A - single-cycle execute results, written directly when selected
//   port B - long-latency results (load / mul-div), buffered in a FIFO
// The chosen result is registered onto we_o / waddr_o / wdata_o, which
// connect straight to the register file's write inputs.
//
// Arbitration, highest priority first:
//   1. FIFO full and port A valid -> the FIFO head is written and A waits.
//      This stops a steady stream on A from starving B.
//   2. port A valid               -> A is written.
//   3. FIFO non-empty             -> the FIFO head is written.
//   4. nothing is written.
// Results addressed to r0 are consumed but never raise we_o.
//
// Optional feature macro: WB_SCOREBOARD_EN
//   defined   - busy_o tracks registers that have an outstanding write.
//               Issue sets a bit, commit clears it, and set wins on a tie.
//   undefined - busy_o is tied to 0 and the iss_* inputs are ignored.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   a_valid_i    port A result valid
//   a_ready_o    port A accepted this cycle
//   a_waddr_i    port A destination register
//   a_wdata_i    port A result
//   b_valid_i    port B result valid
//   b_ready_o    port B FIFO can accept
//   b_waddr_i    port B destination register
//   b_wdata_i    port B result
//   we_o         register-file write enable (registered)
//   waddr_o      register-file write address (registered)
//   wdata_o      register-file write data (registered)
//   iss_valid_i  decode issued an instruction that writes a register
//   iss_waddr_i  destination register of that instruction
//   busy_o       bit n set means r[n] has a pending write

`ifndef RegW
`define RegW 32
`endif

module regfile_wb_arbiter #(
  parameter int RegW       = `RegW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            a_valid_i,
  output logic            a_ready_o,
  input  logic [4:0]      a_waddr_i,
  input  logic [RegW-1:0] a_wdata_i,
  input  logic            b_valid_i,
  output logic            b_ready_o,
  input  logic [4:0]      b_waddr_i,
  input  logic [RegW-1:0] b_wdata_i,
  output logic            we_o,
  output logic [4:0]      waddr_o,
  output logic [RegW-1:0] wdata_o,
  input  logic            iss_valid_i,
  input  logic [4:0]      iss_waddr_i,
  output logic [31:0]     busy_o
);

  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = PtrW + 1;

  typedef struct packed {
    logic [4:0]      addr;
    logic [RegW-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_FIFO
  } sel_e;

  // ---------------------------------------------------------------------
  // Port B FIFO
  // ---------------------------------------------------------------------
  wb_entry_t       fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  assign fifo_full  = (count == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Both ready signals depend only on the count, a_valid_i and rst_i.
  // They never look at b_valid_i.
  assign b_ready_o = ~fifo_full & ~rst_i;
  assign a_ready_o = a_valid_i & ~fifo_full & ~rst_i;

  assign push = b_valid_i & b_ready_o;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  sel_e      sel;
  wb_entry_t sel_entry;

  // NOTE: every output of this block gets a default first. A branch that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    sel       = SEL_NONE;
    sel_entry = '0;
    if (fifo_full && a_valid_i) begin
      sel       = SEL_FIFO;
      sel_entry = fifo_mem[rd_ptr];
    end else if (a_valid_i) begin
      sel       = SEL_A;
      sel_entry = '{addr: a_waddr_i, data: a_wdata_i};
    end else if (!fifo_empty) begin
      sel       = SEL_FIFO;
      sel_entry = fifo_mem[rd_ptr];
    end
  end

  assign pop = (sel == SEL_FIFO);

  // NOTE: sequential state is updated with non-blocking assignments only.
  // Every flop then samples pre-edge values, whatever the block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // The depth is a power of two, so the pointers wrap on their own.
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  // NOTE: the storage array has no reset. Reset clears the count and
  // pointers, so stale entries are unreachable. The array can then map
  // onto plain RAM or flops without reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: b_waddr_i, data: b_wdata_i};
  end

  // ---------------------------------------------------------------------
  // Registered write stream
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (sel != SEL_NONE) begin
      // An r0 result is consumed here but never reaches the register file.
      we_o    <= (sel_entry.addr != 5'd0);
      waddr_o <= sel_entry.addr;
      wdata_o <= sel_entry.data;
    end else begin
      we_o    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q;
  logic [31:0] busy_nxt;

  // Apply the clear before the set. A same-cycle issue to the committing
  // register then leaves its bit set: the new write is still in flight.
  always_comb begin
    busy_nxt = busy_q;
    if (sel != SEL_NONE && sel_entry.addr != 5'd0) busy_nxt[sel_entry.addr] = 1'b0;
    if (iss_valid_i && iss_waddr_i != 5'd0)        busy_nxt[iss_waddr_i]    = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign busy_o = busy_q;
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid_i, iss_waddr_i};
  assign busy_o     = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// A queue-based reference model runs every cycle. Directed table vectors,
// hand-written corner sequences and random traffic are checked against it.

module tb_regfile_wb_arbiter;

  localparam int W     = 32;
  localparam int DEPTH = 4;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          a_valid_i = 1'b0;
  logic          a_ready_o;
  logic [4:0]    a_waddr_i = '0;
  logic [W-1:0]  a_wdata_i = '0;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [4:0]    b_waddr_i = '0;
  logic [W-1:0]  b_wdata_i = '0;
  logic          we_o;
  logic [4:0]    waddr_o;
  logic [W-1:0]  wdata_o;
  logic          iss_valid_i = 1'b0;
  logic [4:0]    iss_waddr_i = '0;
  logic [31:0]   busy_o;

  regfile_wb_arbiter #(.RegW(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .a_valid_i   (a_valid_i),
    .a_ready_o   (a_ready_o),
    .a_waddr_i   (a_waddr_i),
    .a_wdata_i   (a_wdata_i),
    .b_valid_i   (b_valid_i),
    .b_ready_o   (b_ready_o),
    .b_waddr_i   (b_waddr_i),
    .b_wdata_i   (b_wdata_i),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .iss_valid_i (iss_valid_i),
    .iss_waddr_i (iss_waddr_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]   addr;
    logic [W-1:0] data;
  } ent_t;

  ent_t         q[$];
  logic         m_we    = 1'b0;
  logic [4:0]   m_waddr = '0;
  logic [W-1:0] m_wdata = '0;
  logic [31:0]  m_busy  = '0;
  logic         last_ar, last_br;

  // One clock cycle. Inputs are already driven. Check the ready outputs,
  // advance the model, cross the edge, then check the registered outputs.
  task automatic tick();
    bit   full, e_ar, e_br, have;
    ent_t sel;
    #1;
    full = (q.size() == DEPTH);
    e_ar = a_valid_i && !full && !rst_i;
    e_br = !full && !rst_i;
    last_ar = a_ready_o;
    last_br = b_ready_o;
    check("a_ready", a_ready_o, e_ar);
    check("b_ready", b_ready_o, e_br);
    if (rst_i) begin
      q.delete();
      m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
    end else begin
      have = 0;
      sel  = '{addr: 0, data: 0};
      if (full && a_valid_i) begin
        sel = q.pop_front(); have = 1;
      end else if (a_valid_i) begin
        sel = '{addr: a_waddr_i, data: a_wdata_i}; have = 1;
      end else if (q.size() > 0) begin
        sel = q.pop_front(); have = 1;
      end
      if (b_valid_i && e_br) q.push_back('{addr: b_waddr_i, data: b_wdata_i});
      if (have) begin
        m_we = (sel.addr != 0); m_waddr = sel.addr; m_wdata = sel.data;
      end else begin
        m_we = 0;
      end
      if (SB) begin
        if (have && sel.addr != 0) m_busy[sel.addr] = 1'b0;
        if (iss_valid_i && iss_waddr_i != 0) m_busy[iss_waddr_i] = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    check("we", we_o, m_we);
    check("waddr", waddr_o, m_waddr);
    check("wdata", wdata_o, m_wdata);
    check("busy", busy_o, m_busy);
  endtask

  task automatic drive(input logic rst, input logic av, input logic [4:0] aa, input logic [W-1:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [W-1:0] bd,
                       input logic iv, input logic [4:0] ia);
    rst_i = rst; a_valid_i = av; a_waddr_i = aa; a_wdata_i = ad;
    b_valid_i = bv; b_waddr_i = ba; b_wdata_i = bd;
    iss_valid_i = iv; iss_waddr_i = ia;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         rst;
    logic         av;
    logic [4:0]   aa;
    logic [W-1:0] ad;
    logic         bv;
    logic [4:0]   ba;
    logic [W-1:0] bd;
    logic         e_ar;
    logic         e_br;
    logic         e_we;
    logic [4:0]   e_wa;
    logic [W-1:0] e_wd;
  } vec_t;

  vec_t vecs [18];

  initial begin
    // reset with both ports valid; nothing may leak out afterwards
    vecs[0]  = '{1, 1,  3, 'hAA,       1,  4, 'hBB, 0, 0, 0,  0, 'h0};
    vecs[1]  = '{1, 1,  3, 'hAA,       1,  4, 'hBB, 0, 0, 0,  0, 'h0};
    vecs[2]  = '{0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0, 'h0};
    // simultaneous A and B with an empty FIFO
    vecs[3]  = '{0, 1,  5, 'h11,       1,  6, 'h22, 1, 1, 1,  5, 'h11};
    vecs[4]  = '{0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 1,  6, 'h22};
    vecs[5]  = '{0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  6, 'h22};
    // starvation guard: A streams while B fills the FIFO
    vecs[6]  = '{0, 1,  1, 'h100,      1, 10, 'hB0, 1, 1, 1,  1, 'h100};
    vecs[7]  = '{0, 1,  2, 'h101,      1, 11, 'hB1, 1, 1, 1,  2, 'h101};
    vecs[8]  = '{0, 1,  3, 'h102,      1, 12, 'hB2, 1, 1, 1,  3, 'h102};
    vecs[9]  = '{0, 1,  4, 'h103,      1, 13, 'hB3, 1, 1, 1,  4, 'h103};
    vecs[10] = '{0, 1,  5, 'h104,      0,  0, 'h0,  0, 0, 1, 10, 'hB0};
    vecs[11] = '{0, 1,  5, 'h104,      0,  0, 'h0,  1, 1, 1,  5, 'h104};
    vecs[12] = '{0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 1, 11, 'hB1};
    vecs[13] = '{0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 1, 12, 'hB2};
    vecs[14] = '{0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 1, 13, 'hB3};
    vecs[15] = '{0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0, 13, 'hB3};
    // r0 write is accepted but never raises we_o
    vecs[16] = '{0, 1,  0, 'hDEADBEEF, 0,  0, 'h0,  1, 1, 0,  0, 'hDEADBEEF};
    vecs[17] = '{0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0, 'hDEADBEEF};

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad,
            vecs[i].bv, vecs[i].ba, vecs[i].bd, 1'b0, 5'd0);
      tick();
      check($sformatf("vec%0d_a_ready", i), last_ar, vecs[i].e_ar);
      check($sformatf("vec%0d_b_ready", i), last_br, vecs[i].e_br);
      check($sformatf("vec%0d_we", i), we_o, vecs[i].e_we);
      check($sformatf("vec%0d_waddr", i), waddr_o, vecs[i].e_wa);
      check($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].e_wd);
      if (i < 2) check($sformatf("vec%0d_busy", i), busy_o, 32'h0);
    end

    // ---------------- scoreboard ----------------
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
    tick();
    check("sb_r7_set", busy_o[7], SB);
    drive(0, 0, 0, 0, 1, 5'd7, 'h77, 0, 0);
    tick();
    check("sb_r7_pending", busy_o[7], SB);
    check("sb_r7_no_we_yet", we_o, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("sb_r7_we", we_o, 1'b1);
    check("sb_r7_addr", waddr_o, 5'd7);
    check("sb_r7_cleared", busy_o[7], 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    tick();
    check("sb_r9_set", busy_o[9], SB);
    drive(0, 1, 5'd9, 'h99, 0, 0, 0, 1, 5'd9);
    tick();
    check("sb_r9_we", we_o, 1'b1);
    check("sb_r9_set_wins", busy_o[9], SB);
    check("sb_r0_const", busy_o[0], 1'b0);

    // ---------------- reset mid-drain ----------------
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'd1, W'(i), 1, 5'(20 + i), W'('hC0 + i), 0, 0);
      tick();
    end
    check("mid_fifo_holds3", q.size(), 3);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("mid_rst_busy", busy_o, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) check("mid_b_ready_after_rst", last_br, 1'b1);
      check($sformatf("mid_no_we_%0d", i), we_o, 1'b0);
    end

    // ---------------- random traffic vs model ----------------
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), W'($urandom),
            ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 31)), W'($urandom),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
